// File: rtl/mbist_cmp_log.sv
// Registered MBIST comparator: masked gt/eq/lt flags, saturating fail counter,
// first-fail capture and a fail-log FIFO. Define MBIST_CMP_DIAG_EN to add fail_bitmap.
module mbist_cmp_log #(
  parameter int DW        = 8,
  parameter int AW        = 10,
  parameter int CW        = 16,
  parameter int LOG_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          cmp_valid,
  input  logic [DW-1:0] data_t,
  input  logic [DW-1:0] ramout,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] mask,
  output logic          res_valid,
  output logic          gt,
  output logic          eq,
  output logic          lt,
  output logic          fail,
  output logic [CW-1:0] fail_cnt,
  output logic [AW-1:0] ff_addr,
  output logic [DW-1:0] ff_exp,
  output logic [DW-1:0] ff_act,
`ifdef MBIST_CMP_DIAG_EN
  output logic [DW-1:0] fail_bitmap,
`endif
  output logic          log_valid,
  input  logic          log_ready,
  output logic [AW-1:0] log_addr,
  output logic [DW-1:0] log_syndrome,
  output logic          log_overflow
);

  localparam int PW = $clog2(LOG_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(LOG_DEPTH);

  logic [DW-1:0] me, ma, syndrome;
  logic          mismatch, full, pop, push_ok;
  logic [AW-1:0] mem_addr [LOG_DEPTH];
  logic [DW-1:0] mem_syn  [LOG_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;

  assign me       = data_t & ~mask;
  assign ma       = ramout & ~mask;
  assign syndrome = (data_t ^ ramout) & ~mask;
  assign mismatch = cmp_valid & (me != ma);
  assign full     = (count == FULL_CNT);

  // Fail-log handshake: the head entry transfers on any edge where log_valid and
  // log_ready are both high; log_valid never depends on log_ready and the head
  // entry stays stable until it is popped.
  assign log_valid    = (count != '0);
  assign pop          = log_valid & log_ready;
  assign push_ok      = mismatch & (~full | pop);
  assign log_addr     = log_valid ? mem_addr[rd_ptr] : '0;
  assign log_syndrome = log_valid ? mem_syn[rd_ptr]  : '0;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      res_valid    <= 1'b0;
      gt           <= 1'b0;
      eq           <= 1'b0;
      lt           <= 1'b0;
      fail         <= 1'b0;
      fail_cnt     <= '0;
      ff_addr      <= '0;
      ff_exp       <= '0;
      ff_act       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      log_overflow <= 1'b0;
`ifdef MBIST_CMP_DIAG_EN
      fail_bitmap  <= '0;
`endif
    end else begin
      res_valid <= cmp_valid;
      if (cmp_valid) begin
        gt <= (me > ma);
        eq <= (me == ma);
        lt <= (me < ma);
      end
      if (mismatch) begin
        fail <= 1'b1;
        if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
        // Only the very first mismatch since reset/clr is captured.
        if (!fail) begin
          ff_addr <= addr;
          ff_exp  <= data_t;
          ff_act  <= ramout;
        end
`ifdef MBIST_CMP_DIAG_EN
        fail_bitmap <= fail_bitmap | syndrome;
`endif
      end
      if (mismatch && full && !pop) log_overflow <= 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: empty entries are masked off at the outputs.
  always_ff @(posedge clk) begin
    if (rst_n && !clr && push_ok) begin
      mem_addr[wr_ptr] <= addr;
      mem_syn[wr_ptr]  <= syndrome;
    end
  end

endmodule

// File: tb/tb_mbist_cmp_log.sv
// Bench for mbist_cmp_log: directed test-plan scenarios plus random traffic,
// all checked every cycle against a queue-based behavioural model.
module tb_mbist_cmp_log;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam int CW = 3;
  localparam int LOG_DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          cmp_valid = 1'b0;
  logic [DW-1:0] data_t = '0;
  logic [DW-1:0] ramout = '0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] mask = '0;
  logic          log_ready = 1'b0;
  logic          res_valid, gt, eq, lt, fail, log_valid, log_overflow;
  logic [CW-1:0] fail_cnt;
  logic [AW-1:0] ff_addr, log_addr;
  logic [DW-1:0] ff_exp, ff_act, log_syndrome;
`ifdef MBIST_CMP_DIAG_EN
  logic [DW-1:0] fail_bitmap;
`endif

  mbist_cmp_log #(.DW(DW), .AW(AW), .CW(CW), .LOG_DEPTH(LOG_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .cmp_valid(cmp_valid),
    .data_t(data_t), .ramout(ramout), .addr(addr), .mask(mask),
    .res_valid(res_valid), .gt(gt), .eq(eq), .lt(lt), .fail(fail),
    .fail_cnt(fail_cnt), .ff_addr(ff_addr), .ff_exp(ff_exp), .ff_act(ff_act),
`ifdef MBIST_CMP_DIAG_EN
    .fail_bitmap(fail_bitmap),
`endif
    .log_valid(log_valid), .log_ready(log_ready), .log_addr(log_addr),
    .log_syndrome(log_syndrome), .log_overflow(log_overflow)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] s;
  } rec_t;

  rec_t          m_q[$];
  logic          m_res_valid, m_gt, m_eq, m_lt, m_fail, m_ovf;
  int            m_cnt;
  logic [AW-1:0] m_ffa;
  logic [DW-1:0] m_ffe, m_ffact, m_bitmap;
  int            checks = 0;
  int            failures = 0;

  task automatic model_clear();
    m_res_valid = 0; m_gt = 0; m_eq = 0; m_lt = 0; m_fail = 0; m_ovf = 0;
    m_cnt = 0; m_ffa = '0; m_ffe = '0; m_ffact = '0; m_bitmap = '0;
    m_q.delete();
  endtask

  task automatic model_edge();
    int unsigned me, ma;
    logic [DW-1:0] syn;
    if (!rst_n || clr) begin
      model_clear();
    end else begin
      me  = int'(data_t & ~mask);
      ma  = int'(ramout & ~mask);
      syn = (data_t ^ ramout) & ~mask;
      m_res_valid = cmp_valid;
      if (cmp_valid) begin
        m_gt = (me > ma); m_eq = (me == ma); m_lt = (me < ma);
      end
      // Consumer takes the head first, so a full FIFO popped this cycle has room.
      if (m_q.size() > 0 && log_ready) void'(m_q.pop_front());
      if (cmp_valid && me != ma) begin
        if (!m_fail) begin
          m_ffa = addr; m_ffe = data_t; m_ffact = ramout;
        end
        m_fail = 1;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        m_bitmap = m_bitmap | syn;
        if (m_q.size() < LOG_DEPTH) m_q.push_back('{a: addr, s: syn});
        else m_ovf = 1;
      end
    end
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    chk("res_valid", 64'(res_valid), 64'(m_res_valid));
    chk("gt", 64'(gt), 64'(m_gt));
    chk("eq", 64'(eq), 64'(m_eq));
    chk("lt", 64'(lt), 64'(m_lt));
    chk("fail", 64'(fail), 64'(m_fail));
    chk("fail_cnt", 64'(fail_cnt), 64'(m_cnt));
    chk("ff_addr", 64'(ff_addr), 64'(m_ffa));
    chk("ff_exp", 64'(ff_exp), 64'(m_ffe));
    chk("ff_act", 64'(ff_act), 64'(m_ffact));
    chk("log_valid", 64'(log_valid), 64'(m_q.size() > 0));
    chk("log_addr", 64'(log_addr), m_q.size() > 0 ? 64'(m_q[0].a) : 64'd0);
    chk("log_syndrome", 64'(log_syndrome), m_q.size() > 0 ? 64'(m_q[0].s) : 64'd0);
    chk("log_overflow", 64'(log_overflow), 64'(m_ovf));
`ifdef MBIST_CMP_DIAG_EN
    chk("fail_bitmap", 64'(fail_bitmap), 64'(m_bitmap));
`endif
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  // ---------------- driver tasks ----------------
  task automatic cmp(input logic [DW-1:0] d, input logic [DW-1:0] r,
                     input logic [DW-1:0] m, input logic [AW-1:0] a);
    cmp_valid = 1; data_t = d; ramout = r; mask = m; addr = a;
    step();
    cmp_valid = 0;
  endtask

  task automatic idle(input int n);
    cmp_valid = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_clr();
    clr = 1; step(); clr = 0;
  endtask

  initial begin
    model_clear();
    // Reset
    rst_n = 0; idle(2); rst_n = 1;
    chk("reset_fail_cnt", 64'(fail_cnt), 64'd0);
    chk("reset_log_valid", 64'(log_valid), 64'd0);

    // Equal words, then two fails, then fully masked difference
    cmp(8'h5A, 8'h5A, 8'h00, 10'd3);
    chk("tp1_eq", 64'(eq), 64'd1);
    chk("tp1_res_valid", 64'(res_valid), 64'd1);
    cmp(8'h80, 8'h7F, 8'h00, 10'h011);
    chk("tp2_gt", 64'(gt), 64'd1);
    chk("tp2_cnt", 64'(fail_cnt), 64'd1);
    chk("tp2_ff_addr", 64'(ff_addr), 64'h011);
    chk("tp2_ff_act", 64'(ff_act), 64'h7F);
    chk("tp2_syndrome", 64'(log_syndrome), 64'hFF);
    cmp(8'h01, 8'h03, 8'h00, 10'h012);
    chk("tp3_lt", 64'(lt), 64'd1);
    chk("tp3_cnt", 64'(fail_cnt), 64'd2);
    chk("tp3_ff_exp", 64'(ff_exp), 64'h80);
    cmp(8'hF0, 8'h00, 8'hF0, 10'h013);
    chk("tp4_eq", 64'(eq), 64'd1);
    chk("tp4_cnt", 64'(fail_cnt), 64'd2);
    idle(1);
    chk("hold_res_valid", 64'(res_valid), 64'd0);
    chk("hold_eq", 64'(eq), 64'd1);

    // Overflow: 6 mismatches into a 4-deep log, then drain in order
    do_clr();
    log_ready = 0;
    for (int i = 0; i < 6; i++) cmp(8'(i + 1), 8'h00, 8'h00, 10'(10'h100 + i));
    chk("ovf_flag", 64'(log_overflow), 64'd1);
    chk("ovf_cnt", 64'(fail_cnt), 64'd6);
    log_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_addr", 64'(log_addr), 64'(10'h100 + i));
      chk("drain_syn", 64'(log_syndrome), 64'(i + 1));
      step();
    end
    chk("drain_empty", 64'(log_valid), 64'd0);
    log_ready = 0;

    // Full FIFO with simultaneous pop and push
    do_clr();
    for (int i = 0; i < 4; i++) cmp(8'h01, 8'h00, 8'h00, 10'(10'h200 + i));
    log_ready = 1;
    cmp(8'h02, 8'h00, 8'h00, 10'h2AA);
    log_ready = 0;
    chk("fullpop_ovf", 64'(log_overflow), 64'd0);
    chk("fullpop_head", 64'(log_addr), 64'h201);
    log_ready = 1;
    idle(3);
    chk("fullpop_tail", 64'(log_addr), 64'h2AA);
    chk("fullpop_tail_syn", 64'(log_syndrome), 64'h02);
    idle(1);
    chk("fullpop_empty", 64'(log_valid), 64'd0);
    log_ready = 0;

    // Counter saturation, then clr and reset while a mismatch is presented
    do_clr();
    for (int i = 0; i < 9; i++) cmp(8'hFF, 8'h00, 8'h00, 10'(i));
    chk("sat_cnt", 64'(fail_cnt), 64'd7);
    cmp_valid = 1; data_t = 8'h11; ramout = 8'h22; mask = 0; clr = 1;
    step();
    clr = 0; cmp_valid = 0;
    chk("clr_cnt", 64'(fail_cnt), 64'd0);
    chk("clr_fail", 64'(fail), 64'd0);
    chk("clr_res_valid", 64'(res_valid), 64'd0);
    chk("clr_log_valid", 64'(log_valid), 64'd0);
    for (int i = 0; i < 3; i++) cmp(8'h0F, 8'h00, 8'h00, 10'(i));
    cmp_valid = 1; rst_n = 0;
    step();
    rst_n = 1; cmp_valid = 0;
    chk("rst_cnt", 64'(fail_cnt), 64'd0);
    chk("rst_ovf", 64'(log_overflow), 64'd0);
    chk("rst_ff_addr", 64'(ff_addr), 64'd0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      cmp_valid = ($urandom_range(0, 3) != 0);
      data_t    = 8'($urandom);
      ramout    = ($urandom_range(0, 2) == 0) ? data_t : 8'($urandom);
      case ($urandom_range(0, 5))
        0:       mask = 8'hFF;
        1, 2:    mask = 8'($urandom);
        default: mask = 8'h00;
      endcase
      addr      = 10'($urandom);
      log_ready = ($urandom_range(0, 2) == 0);
      clr       = ($urandom_range(0, 99) == 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      step();
    end
    clr = 0; rst_n = 1; cmp_valid = 0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mbist_cmp_log.md
Name: mbist_cmp_log

Overview:
Parametrised, registered successor to the MBIST byte comparator. It compares expected data against SRAM read data over a configurable width with a per-bit don't-care mask, and produces registered gt/eq/lt flags. It also keeps a saturating fail counter, captures the first failing address and data, and buffers fail records (address plus syndrome) in a small FIFO that the MBIST controller or a debug port drains through a valid/ready handshake.

Parameters:
DW, 8, data width in bits of the expected and actual words
AW, 10, SRAM address width
CW, 16, fail counter width
LOG_DEPTH, 4, fail-log FIFO depth in entries; power of two, at least 2

Ports:
clk  in  1  single clock; all logic on the rising edge
rst_n  in  1  synchronous, active-low reset
clr  in  1  synchronous clear of all result, count, capture and log state
cmp_valid  in  1  compare request this cycle
data_t  in  DW  expected data
ramout  in  DW  actual SRAM output
addr  in  AW  address of the word being compared
mask  in  DW  1 = ignore this bit
res_valid  out  1  one-cycle pulse: gt/eq/lt updated
gt  out  1  masked data_t > masked ramout (unsigned)
eq  out  1  masked values equal
lt  out  1  masked data_t < masked ramout
fail  out  1  sticky: at least one mismatch since reset/clr
fail_cnt  out  CW  number of mismatches, saturating
ff_addr  out  AW  address of the first mismatch
ff_exp  out  DW  expected data at the first mismatch
ff_act  out  DW  actual data at the first mismatch
log_valid  out  1  fail-log FIFO not empty
log_ready  in  1  consumer accepts the head entry
log_addr  out  AW  head entry address
log_syndrome  out  DW  head entry syndrome: (data_t ^ ramout) & ~mask
log_overflow  out  1  sticky: a fail record was dropped because the FIFO was full

Behaviour:
- Reset: rst_n low at an edge clears every register. All outputs read 0, including gt/eq/lt, fail_cnt, ff_*, log_valid and log_overflow; the FIFO is empty.
- clr high: same effect as reset. It has priority over cmp_valid and log_ready in that cycle; the input sample is discarded and no pop occurs.
- Compare: masked values are me = data_t & ~mask and ma = ramout & ~mask. gt/eq/lt are one-hot and computed by unsigned comparison of me and ma. Latency is 1: cmp_valid at edge N gives res_valid=1 and the new flags after edge N. With cmp_valid low, res_valid=0 and gt/eq/lt hold their last values.
- Mismatch = cmp_valid & (me != ma). All of the following apply at the same edge:
  - fail is set.
  - fail_cnt increments; at 2^CW-1 it holds.
  - If fail was 0, ff_addr, ff_exp and ff_act capture addr, data_t and ramout (unmasked). Later mismatches never overwrite them.
  - A push of {addr, syndrome} is attempted.
- mask all ones: always eq=1, never a fail.
- FIFO:
  - Pop occurs when log_valid & log_ready.
  - Push is accepted if the FIFO is not full, or if it is full and a pop happens in the same cycle (occupancy unchanged).
  - A push while full with no pop drops the record and sets log_overflow. The count is still updated.
  - Push and pop on an empty FIFO: the pop has no effect because log_valid=0; the push is stored.
  - Pointers wrap modulo LOG_DEPTH. An occupancy counter of width clog2(LOG_DEPTH)+1 is used.
  - log_addr and log_syndrome are driven from the head entry and are 0 when empty.
- No combinational path from any input to any output.

Optional Feature:
MBIST_CMP_DIAG_EN: when defined, an added output fail_bitmap [DW] accumulates the OR of every syndrome since reset/clr. It identifies stuck or faulty bit columns and resets to 0. When not defined, the port and its register are absent; all other behaviour is identical.

Test Plan:
- DW=8. data_t=0x5A, ramout=0x5A, mask=0x00, addr=3 -> next cycle res_valid=1, eq=1; fail=0, fail_cnt=0, log_valid=0.
- data_t=0x80, ramout=0x7F, mask=0, addr=0x011 -> gt=1; fail=1, fail_cnt=1; ff_addr=0x011, ff_exp=0x80, ff_act=0x7F; log_valid=1, log_syndrome=0xFF. A second fail, data_t=0x01, ramout=0x03 at addr 0x012 -> lt=1, fail_cnt=2, ff_* unchanged.
- data_t=0xF0, ramout=0x00, mask=0xF0 -> eq=1, no fail, no push.
- LOG_DEPTH=4 and log_ready=0, issue 6 mismatches -> 4 entries kept in order, log_overflow=1, fail_cnt=6. Then hold log_ready=1 -> 4 pops in order, then log_valid=0.
- FIFO full, log_ready=1 and a mismatch in the same cycle -> the new entry is accepted at the tail, log_overflow stays 0, and occupancy stays 4.
- CW=2, 5 mismatches -> fail_cnt holds at 3. Then clr=1 with cmp_valid=1 -> all outputs 0 and the input is discarded. Repeat using rst_n=0 mid-stream -> same result.
